// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types for the PC generator / fetch front end.
// fetch_tag_t is the default-width tag layout; the top mirrors it at its own XLEN.
package pc_fetch_pkg;
    localparam int TAG_XLEN = 32;
    typedef enum logic [1:0] {RD_NONE, RD_BRANCH, RD_TRAP} redirect_t;
    typedef struct packed {
        logic [TAG_XLEN-1:0] pc;
        logic                epoch;
    } fetch_tag_t;
endpackage

// File: rtl/pc_tag_fifo.sv
// pc_tag_fifo: synchronous tag FIFO with occupancy count.
// Push when full and pop when empty are ignored.
module pc_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 33,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign do_push = push & (count != CW'(DEPTH));
    assign do_pop  = pop & (count != '0);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: PC generator and fetch front end with epoch-tagged in-flight tracking.
// Optional PC_MISALIGN_CHECK_EN adds a sticky misalign_fault that halts issue on a misaligned redirect.
module pc_fetch_gen
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VEC    = '0,
    parameter int              PC_INC       = 4,
    parameter int              STALL_W      = 5,
    parameter int              STALL_BIT    = 2,
    parameter int              MAX_INFLIGHT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               go,
    input  logic               trap,
    input  logic [XLEN-1:0]    trap_addr,
    input  logic               branch,
    input  logic [XLEN-1:0]    branch_addr,
    input  logic [STALL_W-1:0] do_stall,
    output logic               fetch_req_valid,
    input  logic               fetch_req_ready,
    output logic [XLEN-1:0]    fetch_addr,
    input  logic               fetch_rsp_valid,
    input  logic [XLEN-1:0]    fetch_rsp_data,
    output logic               inst_valid,
    output logic [XLEN-1:0]    inst_data,
    output logic [XLEN-1:0]    inst_pc,
`ifdef PC_MISALIGN_CHECK_EN
    output logic               misalign_fault,
`endif
    output logic [XLEN-1:0]    pc_cpu
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            epoch;
    } tag_t;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    redirect_t       rd_src;
    logic [XLEN-1:0] rd_addr;
    logic [CW-1:0]   inflight;
    tag_t            tag_in, tag_out;
    logic            epoch, accept, rd_take, bad_target, halt, rsp_pop, deliver, unused;
    assign unused  = ^do_stall;
    assign rd_src  = !go ? RD_NONE : trap ? RD_TRAP : branch ? RD_BRANCH : RD_NONE;
    assign rd_addr = rd_src == RD_TRAP ? trap_addr : branch_addr;
`ifdef PC_MISALIGN_CHECK_EN
    assign bad_target = rd_src != RD_NONE && rd_addr[1:0] != 2'b00;
    assign halt       = misalign_fault;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) misalign_fault <= 1'b0;
        else if (bad_target) misalign_fault <= 1'b1;
`else
    assign bad_target = 1'b0;
    assign halt       = 1'b0;
`endif
    assign rd_take         = rd_src != RD_NONE && !bad_target;
    assign fetch_req_valid = reset_n & go & ~do_stall[STALL_BIT] & (inflight < CW'(MAX_INFLIGHT))
                             & ~trap & ~branch & ~halt;
    assign accept          = fetch_req_valid & fetch_req_ready;
    assign fetch_addr      = pc_cpu;
    assign tag_in          = '{pc: pc_cpu, epoch: epoch};
    // Epoch compare uses the pre-redirect value, so a same-cycle response from the old stream is kept.
    assign rsp_pop = fetch_rsp_valid & (inflight != '0);
    assign deliver = rsp_pop & (tag_out.epoch == epoch);
    pc_tag_fifo #(.DEPTH(MAX_INFLIGHT), .W(XLEN + 1), .CW(CW)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (accept),
        .din    (tag_in),
        .pop    (rsp_pop),
        .dout   (tag_out),
        .count  (inflight)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pc_cpu <= RESET_VEC;
            epoch  <= 1'b0;
        end else if (rd_take) begin
            pc_cpu <= rd_addr;
            epoch  <= ~epoch;
        end else if (accept) begin
            pc_cpu <= pc_cpu + XLEN'(PC_INC);
        end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else begin
            inst_valid <= deliver;
            if (deliver) begin
                inst_data <= fetch_rsp_data;
                inst_pc   <= tag_out.pc;
            end
        end
    a_rsp_has_tag: assert property (@(posedge clk) disable iff (!reset_n) fetch_rsp_valid |-> inflight != '0);
endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: directed bench for pc_fetch_gen with a one-cycle in-order I-mem responder.
// Instruction word returned for address a is ~a.
module tb_pc_fetch_gen;
    logic        clk = 1'b0, reset_n = 1'b0, go = 1'b0, trap = 1'b0, branch = 1'b0;
    logic        fetch_req_ready = 1'b0, fetch_rsp_valid = 1'b0;
    logic [31:0] trap_addr = '0, branch_addr = '0, fetch_rsp_data = '0;
    logic [4:0]  do_stall = '0;
    logic        fetch_req_valid, inst_valid;
    logic [31:0] fetch_addr, inst_data, inst_pc, pc_cpu;
`ifdef PC_MISALIGN_CHECK_EN
    logic        misalign_fault;
`endif
    int          checks = 0, passed = 0;
    bit          rsp_en = 1'b0;
    logic [31:0] q[$];
    always #5 clk = ~clk;
    pc_fetch_gen dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .go             (go),
        .trap           (trap),
        .trap_addr      (trap_addr),
        .branch         (branch),
        .branch_addr    (branch_addr),
        .do_stall       (do_stall),
        .fetch_req_valid(fetch_req_valid),
        .fetch_req_ready(fetch_req_ready),
        .fetch_addr     (fetch_addr),
        .fetch_rsp_valid(fetch_rsp_valid),
        .fetch_rsp_data (fetch_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
`ifdef PC_MISALIGN_CHECK_EN
        .misalign_fault (misalign_fault),
`endif
        .pc_cpu         (pc_cpu)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask
    task automatic cyc();
        bit          acc;
        logic [31:0] a;
        #1;
        acc = fetch_req_valid && fetch_req_ready;
        a   = fetch_addr;
        @(posedge clk);
        #1;
        if (fetch_rsp_valid) void'(q.pop_front());
        if (acc) q.push_back(a);
        fetch_rsp_valid = rsp_en && q.size() > 0;
        if (fetch_rsp_valid) fetch_rsp_data = ~q[0];
    endtask
    task automatic wait_inst(input string tag, input logic [31:0] exp);
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (inst_valid) begin
                chk({tag, "_pc"}, inst_pc, exp);
                chk({tag, "_data"}, inst_data, ~exp);
                return;
            end
        end
        chk({tag, "_timeout"}, 32'(inst_valid), 32'd1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        go = 1'b1;
        fetch_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_cpu, 32'h0);
        chk("rst_req_valid", 32'(fetch_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        reset_n = 1'b1;
        rsp_en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("seq_addr", fetch_addr, 32'(4 * i));
            if (i >= 2) begin
                chk("seq_inst_valid", 32'(inst_valid), 32'd1);
                chk("seq_inst_pc", inst_pc, 32'(4 * (i - 2)));
                chk("seq_inst_data", inst_data, ~32'(4 * (i - 2)));
            end
            cyc();
        end
        fetch_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_addr", fetch_addr, 32'h10);
            chk("hold_valid", 32'(fetch_req_valid), 32'd1);
            cyc();
        end
        chk("hold_pc", pc_cpu, 32'h10);
        chk("hold_inst_idle", 32'(inst_valid), 32'd0);
        fetch_req_ready = 1'b1;
        repeat (4) cyc();
        rsp_en = 1'b0;
        repeat (2) cyc();
        #1;
        chk("full_blocks", 32'(fetch_req_valid), 32'd0);
        chk("full_pc", pc_cpu, 32'h28);
        branch = 1'b1;
        branch_addr = 32'h100;
        rsp_en = 1'b1;
        cyc();
        branch = 1'b0;
        chk("br_pc", pc_cpu, 32'h100);
        wait_inst("br_drop", 32'h100);
        go = 1'b0;
        #1;
        chk("go0_no_issue", 32'(fetch_req_valid), 32'd0);
        cyc();
        chk("go0_pc", pc_cpu, 32'h108);
        chk("go0_retire_valid", 32'(inst_valid), 32'd1);
        chk("go0_retire_pc", inst_pc, 32'h104);
        branch = 1'b1;
        branch_addr = 32'h500;
        cyc();
        branch = 1'b0;
        chk("go0_branch_ignored", pc_cpu, 32'h108);
        chk("go0_pulse", 32'(inst_valid), 32'd0);
        go = 1'b1;
        trap = 1'b1;
        trap_addr = 32'h80;
        branch = 1'b1;
        branch_addr = 32'h200;
        #1;
        chk("redir_no_issue", 32'(fetch_req_valid), 32'd0);
        cyc();
        trap = 1'b0;
        branch = 1'b0;
        chk("trap_prio_pc", pc_cpu, 32'h80);
        wait_inst("trap", 32'h80);
        branch = 1'b1;
        branch_addr = 32'h300;
        cyc();
        branch = 1'b0;
        chk("old_epoch_valid", 32'(inst_valid), 32'd1);
        chk("old_epoch_pc", inst_pc, 32'h84);
        chk("old_epoch_newpc", pc_cpu, 32'h300);
        do_stall = 5'b00100;
        branch = 1'b1;
        branch_addr = 32'h40;
        cyc();
        branch = 1'b0;
        chk("stall_br_pc", pc_cpu, 32'h40);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_no_issue", 32'(fetch_req_valid), 32'd0);
            cyc();
        end
        chk("stall_pc_hold", pc_cpu, 32'h40);
        do_stall = 5'b11011;
        #1;
        chk("other_stall_bits", 32'(fetch_req_valid), 32'd1);
        wait_inst("stall_br", 32'h40);
        do_stall = 5'b00000;
        branch = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        cyc();
        branch = 1'b0;
        #1;
        chk("wrap_addr", fetch_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc", pc_cpu, 32'h0);
        wait_inst("wrap", 32'hFFFF_FFFC);
        branch = 1'b1;
        branch_addr = 32'h42;
        cyc();
        branch = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        chk("misalign_fault", 32'(misalign_fault), 32'd1);
        chk("misalign_pc_hold", pc_cpu, 32'h4);
        #1;
        chk("misalign_no_issue", 32'(fetch_req_valid), 32'd0);
`else
        chk("unaligned_pc", pc_cpu, 32'h42);
        #1;
        chk("unaligned_issue", 32'(fetch_req_valid), 32'd1);
`endif
        rsp_en = 1'b0;
        cyc();
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc_cpu, 32'h0);
        chk("mid_rst_valid", 32'(fetch_req_valid), 32'd0);
        chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_inst_data", inst_data, 32'h0);
        chk("mid_rst_inst_pc", inst_pc, 32'h0);
        q.delete();
        fetch_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rsp_en = 1'b1;
        #1;
        chk("post_rst_addr", fetch_addr, 32'h0);
        wait_inst("post_rst", 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
